// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle fill engine for the 640x480x24 framebuffer.
// Takes one (x, y, w, h, colour) command per handshake, clips it to the
// visible area and streams one pixel write per accepted cycle. The address
// order follows the serpentine layout used by the scan-out side: odd rows
// are stored right-to-left.
module vga_rect_fill #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 19,
  parameter bit SERPENTINE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              clipped
);

  localparam logic [10:0] H_RES_W = 11'(H_RES);
  localparam logic [10:0] V_RES_W = 11'(V_RES);
  localparam logic [9:0]  H_LAST  = 10'(H_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clipped_q, clipped_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          cx_q, cx_d;
  logic [9:0]          cy_q, cy_d;
  logic [10:0]         xe_q, xe_d;
  logic [10:0]         ye_q, ye_d;

  logic [10:0]         sum_x_s, sum_y_s;
  logic [10:0]         xe_s, ye_s;
  logic                clip_s, noop_s;
  logic [10:0]         cx_inc_s, cy_inc_s;
  logic                row_end_s, last_s;
  logic [9:0]          nx_s, ny_s;

  // Framebuffer word address of column cx in row cy: cy*640 built from two
  // shifts, plus the column, mirrored on odd rows when serpentine is enabled.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] cx,
                                                 input logic [9:0] cy);
    logic [9:0]        px;
    logic [ADDR_W-1:0] cy_w;
    if (SERPENTINE && cy[0]) begin
      px = H_LAST - cx;
    end else begin
      px = cx;
    end
    cy_w = {{(ADDR_W-10){1'b0}}, cy};
    return (cy_w << 9) + (cy_w << 7) + {{(ADDR_W-10){1'b0}}, px};
  endfunction

  // Clip the incoming command against the screen (11-bit sums cannot overflow).
  always_comb begin
    sum_x_s = {1'b0, cmd_x} + {1'b0, cmd_w};
    sum_y_s = {1'b0, cmd_y} + {1'b0, cmd_h};
    if (sum_x_s > H_RES_W) begin
      xe_s = H_RES_W;
    end else begin
      xe_s = sum_x_s;
    end
    if (sum_y_s > V_RES_W) begin
      ye_s = V_RES_W;
    end else begin
      ye_s = sum_y_s;
    end
    clip_s = (sum_x_s > H_RES_W) | (sum_y_s > V_RES_W);
    noop_s = (cmd_w == 10'd0) | (cmd_h == 10'd0) |
             ({1'b0, cmd_x} >= H_RES_W) | ({1'b0, cmd_y} >= V_RES_W);
  end

  // Raster stepping: next (cx, cy) and end-of-row / end-of-rectangle flags.
  always_comb begin
    cx_inc_s  = {1'b0, cx_q} + 11'd1;
    cy_inc_s  = {1'b0, cy_q} + 11'd1;
    row_end_s = (cx_inc_s == xe_q);
    last_s    = row_end_s & (cy_inc_s == ye_q);
    if (row_end_s) begin
      nx_s = x_q;
      ny_s = cy_q + 10'd1;
    end else begin
      nx_s = cx_q + 10'd1;
      ny_s = cy_q;
    end
  end

  // Next-state and registered-output logic for the IDLE/FILL/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clipped_d   = clipped_q;
    x_d         = x_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    xe_d        = xe_q;
    ye_d        = ye_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          x_d         = cmd_x;
          cx_d        = cmd_x;
          cy_d        = cmd_y;
          xe_d        = xe_s;
          ye_d        = ye_s;
          clipped_d   = clip_s;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (noop_s) begin
            // Nothing visible to draw: report completion straight away.
            state_d = ST_DONE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FILL;
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr(cmd_x, cmd_y);
            wr_data_d = cmd_color;
          end
        end else begin
          cmd_ready_d = 1'b1;
          wr_en_d     = 1'b0;
          busy_d      = 1'b0;
        end
      end

      ST_FILL: begin
        if (wr_en_q && wr_ready) begin
          if (last_s) begin
            state_d = ST_DONE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cx_d      = nx_s;
            cy_d      = ny_s;
            wr_addr_d = pix_addr(nx_s, ny_s);
          end
        end else begin
          // Memory stalled: address and data stay exactly as presented.
          wr_en_d = wr_en_q;
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        wr_en_d     = 1'b0;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
        wr_en_d     = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clipped_q   <= 1'b0;
      x_q         <= 10'd0;
      cx_q        <= 10'd0;
      cy_q        <= 10'd0;
      xe_q        <= 11'd0;
      ye_q        <= 11'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clipped_q   <= clipped_d;
      x_q         <= x_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign clipped   = clipped_q;

endmodule
